// File: rtl/fault_sim_pkg.sv
// Shared types and defaults for the fault-dictionary response collector.
package fault_sim_pkg;
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_REPORT} state_t;

  localparam int          DEF_OUT_W     = 26;
  localparam int          DEF_TEST_CNT  = 66;
  localparam logic [25:0] DEF_MISR_POLY = 26'h2000023;

  // Index must reach TEST_CNT itself, which doubles as the "none/saturated" value.
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register: shift left, fold MSB through POLY, xor in data.
module misr_reg import fault_sim_pkg::*; #(
  parameter int               OUT_W = DEF_OUT_W,
  parameter logic [OUT_W-1:0] POLY  = OUT_W'(DEF_MISR_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [OUT_W-1:0] din,
  output logic [OUT_W-1:0] sig
);
  logic [OUT_W-1:0] r_sig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      r_sig <= '0;
    else if (clr) r_sig <= '0;
    else if (en)  r_sig <= {r_sig[OUT_W-2:0], 1'b0} ^ (r_sig[OUT_W-1] ? POLY : '0) ^ din;
  end

  assign sig = r_sig;
endmodule

// File: rtl/fault_syndrome_collector.sv
// Per-fault golden/faulty comparator: builds syndrome or MISR signature, emits one record per fault.
module fault_syndrome_collector import fault_sim_pkg::*; #(
  parameter int               OUT_W     = DEF_OUT_W,
  parameter int               TEST_CNT  = DEF_TEST_CNT,
  parameter int               CNT_W     = 16,
  parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(DEF_MISR_POLY)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            stats_clr,
  input  logic                            fault_start,
  input  logic                            mode,
  input  logic                            pat_valid,
  input  logic                            pat_last,
  input  logic [OUT_W-1:0]                golden,
  input  logic [OUT_W-1:0]                faulty,
  output logic                            busy,
  output logic                            rec_valid,
  input  logic                            rec_ready,
  output logic [TEST_CNT-1:0]             rec_syndrome,
  output logic [OUT_W-1:0]                rec_signature,
  output logic                            rec_detected,
  output logic [idx_w(TEST_CNT)-1:0]      rec_first_fail,
  output logic [idx_w(TEST_CNT)-1:0]      rec_fail_cnt,
  output logic [CNT_W-1:0]                det_count,
  output logic [CNT_W-1:0]                fault_count,
  output logic                            overflow
);
  localparam int            IW  = idx_w(TEST_CNT);
  localparam logic [IW-1:0] LIM = IW'(TEST_CNT);

  state_t              r_state;
  logic                r_mode, r_busy, r_valid, r_det, r_ovf;
  logic [IW-1:0]       r_idx, r_ff, r_fcnt;
  logic [TEST_CNT-1:0] r_syn;
  logic [CNT_W-1:0]    r_dc, r_fc;

  logic [OUT_W-1:0] w_diff, w_sig;
  logic             w_mis, w_acc, w_start, w_hs;

  assign w_diff  = golden ^ faulty;
  assign w_mis   = |w_diff;
  assign w_acc   = (r_state == S_COLLECT) && pat_valid;
  assign w_start = (r_state == S_IDLE) && fault_start;
  assign w_hs    = r_valid && rec_ready;

  misr_reg #(.OUT_W(OUT_W), .POLY(MISR_POLY)) u_misr (
    .clk (clk),
    .rst (rst),
    .en  (w_acc && r_mode),
    .clr (w_start),
    .din (w_diff),
    .sig (w_sig)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_det   <= 1'b0;
      r_idx   <= '0;
      r_ff    <= LIM;
      r_fcnt  <= '0;
      r_syn   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (fault_start) begin
          r_mode  <= mode;
          r_syn   <= '0;
          r_fcnt  <= '0;
          r_idx   <= '0;
          r_ff    <= LIM;
          r_det   <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= S_COLLECT;
        end
        S_COLLECT: if (pat_valid) begin
          // r_idx saturates at LIM, so LIM marks "beyond the syndrome window"
          if (r_idx != LIM) begin
            r_syn[r_idx] <= w_mis;
            r_idx        <= r_idx + 1'b1;
          end
          if (w_mis && !r_det)         r_ff   <= r_idx;
          if (w_mis)                   r_det  <= 1'b1;
          if (w_mis && r_fcnt != LIM)  r_fcnt <= r_fcnt + 1'b1;
          if (pat_last) begin
            r_valid <= 1'b1;
            r_state <= S_REPORT;
          end
        end
        S_REPORT: if (rec_ready) begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Coverage statistics; a coincident clear beats the handshake update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dc  <= '0;
      r_fc  <= '0;
      r_ovf <= 1'b0;
    end else if (stats_clr) begin
      r_dc  <= '0;
      r_fc  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_hs && !(&r_fc))         r_fc  <= r_fc + 1'b1;
      if (w_hs && r_det && !(&r_dc)) r_dc <= r_dc + 1'b1;
      if (w_acc && r_idx == LIM)    r_ovf <= 1'b1;
    end
  end

  assign busy           = r_busy;
  assign rec_valid      = r_valid;
  assign rec_syndrome   = r_syn;
  assign rec_signature  = w_sig;
  assign rec_detected   = r_det;
  assign rec_first_fail = r_ff;
  assign rec_fail_cnt   = r_fcnt;
  assign det_count      = r_dc;
  assign fault_count    = r_fc;
  assign overflow       = r_ovf;
endmodule

// File: tb/tb_fault_syndrome_collector.sv
// Scoreboard bench: session model pushes expected records, a monitor pops them on handshake.
module tb_fault_syndrome_collector;
  localparam int          OUT_W = 26;
  localparam int          TC    = 66;
  localparam int          CNT_W = 16;
  localparam logic [25:0] POLY  = 26'h2000023;

  logic             clk = 1'b0, rst = 1'b1, stats_clr = 1'b0, fault_start = 1'b0, mode = 1'b0;
  logic             pat_valid = 1'b0, pat_last = 1'b0, rec_ready = 1'b1;
  logic [OUT_W-1:0] golden = '0, faulty = '0;
  logic             busy, rec_valid, rec_detected, overflow;
  logic [TC-1:0]    rec_syndrome;
  logic [OUT_W-1:0] rec_signature;
  logic [6:0]       rec_first_fail, rec_fail_cnt;
  logic [CNT_W-1:0] det_count, fault_count;

  fault_syndrome_collector dut (
    .clk(clk), .rst(rst), .stats_clr(stats_clr), .fault_start(fault_start), .mode(mode),
    .pat_valid(pat_valid), .pat_last(pat_last), .golden(golden), .faulty(faulty),
    .busy(busy), .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_syndrome(rec_syndrome),
    .rec_signature(rec_signature), .rec_detected(rec_detected), .rec_first_fail(rec_first_fail),
    .rec_fail_cnt(rec_fail_cnt), .det_count(det_count), .fault_count(fault_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TC-1:0]    syn;
    logic [OUT_W-1:0] sig;
    logic             det;
    logic [6:0]       ff;
    logic [6:0]       fc;
  } rec_t;

  rec_t             sb_q[$];
  logic [OUT_W-1:0] pat_q[$];
  int n_chk = 0, n_fail = 0;
  int exp_fc = 0, exp_dc = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor samples late in the low phase, after the bench's negedge drives settle.
  always @(negedge clk) begin
    rec_t e;
    #3;
    if (rec_valid && rec_ready) begin
      if (sb_q.size() == 0) chk("unexpected_rec", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk("rec_syndrome",   rec_syndrome,   e.syn);
        chk("rec_signature",  rec_signature,  e.sig);
        chk("rec_detected",   rec_detected,   e.det);
        chk("rec_first_fail", rec_first_fail, e.ff);
        chk("rec_fail_cnt",   rec_fail_cnt,   e.fc);
      end
    end
  end

  task automatic run_session(input logic md);
    rec_t e;
    int idx;
    logic [OUT_W-1:0] d, g;
    e = '0; e.ff = 7'(TC); idx = 0;
    @(negedge clk); fault_start = 1'b1; mode = md;
    @(negedge clk); fault_start = 1'b0;
    for (int i = 0; i < pat_q.size(); i++) begin
      d = pat_q[i]; g = OUT_W'($urandom);
      pat_valid = 1'b1; pat_last = (i == pat_q.size() - 1); golden = g; faulty = g ^ d;
      if (idx < TC) e.syn[idx] = |d;
      if ((|d) && !e.det) e.ff = 7'(idx);
      if (|d) e.det = 1'b1;
      if ((|d) && e.fc < TC) e.fc = e.fc + 7'd1;
      if (idx < TC) idx++;
      if (md) e.sig = {e.sig[OUT_W-2:0], 1'b0} ^ (e.sig[OUT_W-1] ? POLY : '0) ^ d;
      @(negedge clk);
    end
    pat_valid = 1'b0; pat_last = 1'b0;
    sb_q.push_back(e);
    exp_fc++;
    if (e.det) exp_dc++;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    chk({tag, "_drain"}, sb_q.size(), 0);
    sb_q.delete();
    @(negedge clk);
    chk({tag, "_fault_count"}, fault_count, exp_fc);
    chk({tag, "_det_count"},   det_count,   exp_dc);
    chk({tag, "_busy"},        busy,        0);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !rec_valid; i++) @(negedge clk);
    chk("rec_valid_timeout", rec_valid, 1);
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_rec_valid", rec_valid, 0);
    chk("rst_first_fail", rec_first_fail, TC);
    chk("rst_syndrome", rec_syndrome, 0);
    chk("rst_counts", {det_count, fault_count, overflow}, 0);
    rst = 1'b0;

    // mismatches on patterns 1 and 3
    pat_q = '{26'h0, 26'h40, 26'h0, 26'h3};
    run_session(1'b0);
    drain("s4");
    chk("s4_syn_const", rec_syndrome, 66'b1010);
    chk("s4_ff_const", {rec_first_fail, rec_fail_cnt}, {7'd1, 7'd2});

    pat_q.delete();
    for (int i = 0; i < TC; i++) pat_q.push_back('0);
    run_session(1'b0);
    drain("match66");
    chk("match66_ff", rec_first_fail, TC);

    // backpressure with ignored start/pattern pulses
    rec_ready = 1'b0;
    pat_q = '{26'h0, 26'h1, 26'h1};
    run_session(1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      fault_start = 1'b1; pat_valid = 1'b1; pat_last = 1'b1; golden = '0; faulty = '1;
      chk("bp_valid", rec_valid, 1);
      chk("bp_syn", rec_syndrome, sb_q[0].syn);
      chk("bp_fc_hold", fault_count, exp_fc - 1);
    end
    @(negedge clk);
    fault_start = 1'b0; pat_valid = 1'b0; pat_last = 1'b0; rec_ready = 1'b1;
    drain("bp");

    pat_q.delete();
    for (int i = 0; i < 70; i++) pat_q.push_back(i == 68 ? 26'h80_0001 : 26'h0);
    run_session(1'b0);
    drain("ovf");
    chk("ovf_flag", overflow, 1);
    chk("ovf_fields", {rec_first_fail, rec_fail_cnt, rec_detected}, {7'd66, 7'd1, 1'b1});

    pat_q = '{26'h1, 26'h8};
    run_session(1'b1);
    drain("misr2");
    chk("misr2_sig_const", rec_signature, 26'hA);

    pat_q.delete();
    for (int i = 0; i < 12; i++) pat_q.push_back(OUT_W'($urandom) | 26'h200_0000);
    run_session(1'b1);
    drain("misr_rand");

    pat_q = '{26'h0, 26'h0, 26'h0};
    run_session(1'b1);
    drain("misr_match");

    // async reset mid-session
    @(negedge clk); fault_start = 1'b1; mode = 1'b0;
    @(negedge clk); fault_start = 1'b0; pat_valid = 1'b1; golden = '0; faulty = 26'h5;
    @(negedge clk); @(negedge clk); pat_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_syn", rec_syndrome, 0);
    chk("arst_counts", {det_count, fault_count}, 0);
    chk("arst_first_fail", rec_first_fail, TC);
    @(negedge clk); rst = 1'b0;
    exp_fc = 0; exp_dc = 0;
    pat_q = '{26'h0, 26'h0, 26'h0, 26'h0};
    run_session(1'b0);
    drain("post_rst");

    // stats_clr coincident with handshake
    rec_ready = 1'b0;
    pat_q = '{26'h10, 26'h0};
    run_session(1'b0);
    wait_valid();
    @(negedge clk); rec_ready = 1'b1; stats_clr = 1'b1;
    @(negedge clk); stats_clr = 1'b0;
    exp_fc = 0; exp_dc = 0;
    drain("clr_hs");
    chk("clr_overflow", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/fault_syndrome_collector.md
Name: fault_syndrome_collector

Overview:
Synthesizable per-fault response collector for on-chip fault-dictionary generation.
- Compares golden vs faulty-circuit outputs pattern by pattern.
- Builds a per-fault pass/fail syndrome, or a MISR signature of the error vector.
- Emits one record per fault over a valid/ready handshake and keeps running detected/fault counts for coverage.
- Sits between the pattern sequencer and the dictionary writer.

Parameters:
OUT_W, 26, output width of the circuit under test (2..64)
TEST_CNT, 66, max patterns per fault (syndrome length)
CNT_W, 16, width of fault/detected counters
MISR_POLY, 26'h2000023, MISR feedback taps (OUT_W bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
stats_clr  in  1  sync clear of det_count, fault_count, overflow
fault_start  in  1  open new fault session (accepted in IDLE only)
mode  in  1  0=syndrome, 1=MISR; sampled with fault_start
pat_valid  in  1  golden/faulty pair valid this cycle
pat_last  in  1  qualifies final pattern of session
golden  in  OUT_W  fault-free response
faulty  in  OUT_W  faulty response
busy  out  1  high in COLLECT or REPORT
rec_valid  out  1  record available
rec_ready  in  1  record consumer ready
rec_syndrome  out  TEST_CNT  bit i = pattern i mismatched
rec_signature  out  OUT_W  MISR state (0 in syndrome mode)
rec_detected  out  1  any mismatch in session
rec_first_fail  out  $clog2(TEST_CNT+1)  index of first mismatch; TEST_CNT if none
rec_fail_cnt  out  $clog2(TEST_CNT+1)  mismatching patterns, saturating
det_count  out  CNT_W  detected faults, saturating
fault_count  out  CNT_W  faults reported, saturating
overflow  out  1  sticky: session exceeded TEST_CNT patterns

Behaviour:
- Reset: all outputs 0; state IDLE; internal index 0; rec_first_fail = TEST_CNT.
- FSM states: IDLE, COLLECT, REPORT.
- IDLE, on fault_start:
  - latch mode; clear syndrome, signature, fail count; idx = 0; first_fail = TEST_CNT.
  - next state COLLECT.
  - pat_valid in IDLE is ignored.
- COLLECT, on each pat_valid:
  - mis = |(golden ^ faulty).
  - if idx < TEST_CNT: syndrome[idx] = mis. Otherwise the pattern is not stored and overflow is set (sticky); mis still updates detected, fail count and MISR.
  - first_fail = idx on the first mis.
  - fail count increments on mis, saturating at TEST_CNT.
  - idx increments, saturating at TEST_CNT.
  - mode 1: sig <= {sig[OUT_W-2:0],1'b0} ^ (sig[OUT_W-1] ? MISR_POLY : 0) ^ (golden ^ faulty).
  - pat_valid & pat_last: update as above, then REPORT next cycle.
- Record latency: rec_valid rises on the cycle after the pat_last sample.
- REPORT:
  - rec_* are held stable while rec_valid & !rec_ready.
  - On rec_valid & rec_ready: fault_count += 1, det_count += rec_detected (both saturate at all-ones); then IDLE the same edge, rec_valid drops.
  - fault_start and pat_valid in REPORT are ignored.
  - Record fields stay readable after the handshake until the next fault_start.
- fault_start in COLLECT is ignored; sessions end only on pat_last.
- stats_clr:
  - Clears det_count, fault_count and overflow.
  - If it coincides with a handshake, clear wins: counters end at 0.
- Async rst mid-session: abort to IDLE, record discarded, counters zeroed.
- Syndrome mode: detection requires at least one mismatch. MISR mode: rec_detected also derives from mismatches, not from signature!=0, so aliasing never hides a detection.

Decomposition:
- Package fault_sim_pkg: FSM state enum, default OUT_W/TEST_CNT, MISR_POLY constant, index-width function.
- One sub-module, misr_reg (parametrised OUT_W/POLY, enable, sync clear, async rst); instantiated once.

Test Plan:
- Syndrome, 4 patterns, mismatches on patterns 1 and 3, rec_ready=1 → rec_syndrome=...1010, first_fail=1, fail_cnt=2, detected=1, det_count=1, fault_count=1.
- 66 matching patterns → syndrome=0, detected=0, first_fail=66, det_count unchanged, fault_count+1.
- Backpressure: rec_ready low 5 cycles in REPORT; pulse fault_start and pat_valid meanwhile → record stable, inputs ignored, one count update on release.
- 70 patterns with a mismatch only at pattern 68 → overflow=1, syndrome=0, detected=1, fail_cnt=1.
- MISR, OUT_W=4, POLY=4'h3, diffs 4'h1 then 4'h8 → signature 4'hA. Also replay all-match → signature 0.
- rst asserted mid-COLLECT, then a fresh session → no stale syndrome bits, counters 0. stats_clr coincident with handshake → counters 0.
